call_scheduler: RTL and testbench

- Consumes debounced call pulses from the button handler and the car position reported by the movement engine.
- Produces pending-call LEDs and a target-floor request with a valid/arrived handshake toward the movement engine.
- Implements a direction-preserving (SCAN) dispatcher for a 3-floor car, with door-hold timing and an emergency halt.
- Sits between button handling and movement, on the divided clock.

---
 rtl/call_scheduler.sv | 163 ++++++++++++++++
 tb/tb_call_scheduler.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/call_scheduler.sv
// SCAN call dispatcher for a 3-floor car: latches call buttons, picks a target
// floor, and holds the door open after arrivals. It also handles emergency halt.
module call_scheduler #(
    parameter int DOOR_CYCLES = 3
) (
    input  logic       clk,
    input  logic       button_reset,
    input  logic [2:0] call_pulse,
    input  logic [1:0] cur_floor,
    input  logic       arrived,
    input  logic       halt,
    output logic [2:0] calls,
    output logic [1:0] target_floor,
    output logic       target_valid,
    output logic       dir_up,
    output logic       door_cmd
);
    localparam int CW = (DOOR_CYCLES < 2) ? 1 : $clog2(DOOR_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, DISPATCH, DOOR, HALT} state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0]    calls_n, clr, cur_mask;
    logic [1:0]    tgt_n, up_floor, down_floor, pass_floor;
    logic          tv_n, dir_n, door_n, up_hit, down_hit, pass_hit;

    always_comb begin
        case (cur_floor)
            2'd1:    cur_mask = 3'b001;
            2'd2:    cur_mask = 3'b010;
            2'd3:    cur_mask = 3'b100;
            default: cur_mask = 3'b000;
        endcase
    end

    // Nearest pending floor above/below the car, plus the pass-by candidate
    // that lies strictly between car and target in the direction of travel.
    always_comb begin
        up_hit     = 1'b0;
        up_floor   = 2'd1;
        down_hit   = 1'b0;
        down_floor = 2'd1;
        pass_hit   = 1'b0;
        pass_floor = 2'd1;
        for (int f = 3; f >= 1; f--) begin
            if (f > int'(cur_floor) && calls[f-1]) begin
                up_hit   = 1'b1;
                up_floor = 2'(f);
            end
        end
        for (int f = 1; f <= 3; f++) begin
            if (f < int'(cur_floor) && calls[f-1]) begin
                down_hit   = 1'b1;
                down_floor = 2'(f);
            end
            if (call_pulse[f-1] && cur_floor != 2'd0 &&
                (dir_up ? (f > int'(cur_floor) && f < int'(target_floor))
                        : (f < int'(cur_floor) && f > int'(target_floor)))) begin
                pass_hit   = 1'b1;
                pass_floor = 2'(f);
            end
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        clr     = 3'b000;
        tgt_n   = target_floor;
        tv_n    = 1'b0;
        dir_n   = dir_up;
        door_n  = 1'b0;
        case (state)
            IDLE: begin
                if (halt) begin
                    state_n = HALT;
                    door_n  = 1'b1;
                end else if (cur_floor == 2'd0 || calls == 3'b000) begin
                    state_n = IDLE;
                end else if (|(calls & cur_mask)) begin
                    state_n = DOOR;
                    clr     = cur_mask;
                    cnt_n   = CW'(DOOR_CYCLES);
                    door_n  = 1'b1;
                end else begin
                    state_n = DISPATCH;
                    tv_n    = 1'b1;
                    if (dir_up) begin
                        if (up_hit) tgt_n = up_floor;
                        else begin
                            tgt_n = down_floor;
                            dir_n = 1'b0;
                        end
                    end else begin
                        if (down_hit) tgt_n = down_floor;
                        else begin
                            tgt_n = up_floor;
                            dir_n = 1'b1;
                        end
                    end
                end
            end
            DISPATCH: begin
                if (halt) begin
                    state_n = HALT;
                    door_n  = 1'b1;
                end else if (arrived && cur_floor == target_floor) begin
                    state_n = DOOR;
                    clr     = cur_mask;
                    cnt_n   = CW'(DOOR_CYCLES);
                    door_n  = 1'b1;
                end else begin
                    tv_n = 1'b1;
                    if (pass_hit) tgt_n = pass_floor;
                end
            end
            DOOR: begin
                // The door is open here, so calls at this floor never latch.
                clr = cur_mask;
                if (halt) begin
                    state_n = HALT;
                    door_n  = 1'b1;
                end else if (|(call_pulse & cur_mask)) begin
                    cnt_n  = CW'(DOOR_CYCLES);
                    door_n = 1'b1;
                end else if (cnt == CW'(1)) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end else begin
                    cnt_n  = cnt - 1'b1;
                    door_n = 1'b1;
                end
            end
            HALT: begin
                if (halt) door_n = 1'b1;
                else state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
        calls_n = (calls | call_pulse) & ~clr;
    end

    always_ff @(posedge clk) begin
        if (button_reset) begin
            state        <= IDLE;
            calls        <= 3'b000;
            target_floor <= 2'd1;
            target_valid <= 1'b0;
            dir_up       <= 1'b1;
            door_cmd     <= 1'b0;
            cnt          <= '0;
        end else begin
            state        <= state_n;
            calls        <= calls_n;
            target_floor <= tgt_n;
            target_valid <= tv_n;
            dir_up       <= dir_n;
            door_cmd     <= door_n;
            cnt          <= cnt_n;
        end
    end
endmodule

// File: tb/tb_call_scheduler.sv
// Directed bench for call_scheduler: dispatch, pass-by, SCAN reversal, door
// hold and extension, emergency halt, reset and invalid-position cases.
module tb_call_scheduler;
    logic       clk = 1'b0;
    logic       button_reset, arrived, halt;
    logic [2:0] call_pulse, calls;
    logic [1:0] cur_floor, target_floor;
    logic       target_valid, dir_up, door_cmd;
    int         n_chk = 0;
    int         n_err = 0;

    call_scheduler #(.DOOR_CYCLES(3)) dut (
        .clk(clk), .button_reset(button_reset), .call_pulse(call_pulse),
        .cur_floor(cur_floor), .arrived(arrived), .halt(halt),
        .calls(calls), .target_floor(target_floor), .target_valid(target_valid),
        .dir_up(dir_up), .door_cmd(door_cmd)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic [2:0] c);
        call_pulse = c;
        tick();
        call_pulse = 3'b000;
    endtask

    // Arrive at floor f and ride out the full door hold back to IDLE.
    task automatic serve(input logic [1:0] f);
        cur_floor = f;
        arrived   = 1'b1;
        tick();
        arrived = 1'b0;
        repeat (3) tick();
    endtask

    initial begin
        button_reset = 1'b1;
        call_pulse   = 3'b111;
        cur_floor    = 2'd0;
        arrived      = 1'b0;
        halt         = 1'b0;
        tick(); tick();
        chk("rst_calls", 8'(calls), 8'h0);
        chk("rst_tgt", 8'(target_floor), 8'd1);
        chk("rst_tv", 8'(target_valid), 8'd0);
        chk("rst_dir", 8'(dir_up), 8'd1);
        chk("rst_door", 8'(door_cmd), 8'd0);
        button_reset = 1'b0;
        call_pulse   = 3'b000;
        cur_floor    = 2'd1;
        tick();

        // basic dispatch 1 -> 3
        pulse(3'b100);
        chk("bd_calls", 8'(calls), 8'h4);
        chk("bd_tv0", 8'(target_valid), 8'd0);
        tick();
        chk("bd_tv1", 8'(target_valid), 8'd1);
        chk("bd_tgt", 8'(target_floor), 8'd3);
        chk("bd_dir", 8'(dir_up), 8'd1);
        cur_floor = 2'd2; arrived = 1'b1; tick(); arrived = 1'b0;
        chk("mis_arr_tv", 8'(target_valid), 8'd1);
        chk("mis_arr_tgt", 8'(target_floor), 8'd3);
        cur_floor = 2'd3; arrived = 1'b1; tick(); arrived = 1'b0;
        chk("bd_door1", 8'(door_cmd), 8'd1);
        chk("bd_tv_off", 8'(target_valid), 8'd0);
        chk("bd_cleared", 8'(calls), 8'h0);
        tick(); chk("bd_door2", 8'(door_cmd), 8'd1);
        tick(); chk("bd_door3", 8'(door_cmd), 8'd1);
        tick(); chk("bd_door_end", 8'(door_cmd), 8'd0);

        // pass-by: dispatch 1 -> 3, new call at 2 retargets
        cur_floor = 2'd1;
        pulse(3'b100); tick();
        chk("pb_tgt3", 8'(target_floor), 8'd3);
        pulse(3'b010);
        chk("pb_tgt2", 8'(target_floor), 8'd2);
        chk("pb_calls", 8'(calls), 8'h6);
        cur_floor = 2'd2; arrived = 1'b1; tick(); arrived = 1'b0;
        chk("pb_door", 8'(door_cmd), 8'd1);
        chk("pb_calls2", 8'(calls), 8'h4);
        repeat (3) tick();
        chk("pb_idle_door", 8'(door_cmd), 8'd0);
        chk("pb_idle_tv", 8'(target_valid), 8'd0);
        tick();
        chk("pb_re_tv", 8'(target_valid), 8'd1);
        chk("pb_re_tgt", 8'(target_floor), 8'd3);
        chk("pb_re_dir", 8'(dir_up), 8'd1);
        serve(2'd3);

        // SCAN: reverse at top, then keep down with calls on both sides
        pulse(3'b010); tick();
        chk("sc_tgt2", 8'(target_floor), 8'd2);
        chk("sc_dir0", 8'(dir_up), 8'd0);
        serve(2'd2);
        pulse(3'b101);
        chk("sc_calls", 8'(calls), 8'h5);
        tick();
        chk("sc_tgt1", 8'(target_floor), 8'd1);
        chk("sc_dir_keep", 8'(dir_up), 8'd0);
        serve(2'd1);
        tick();
        chk("sc_tgt3", 8'(target_floor), 8'd3);
        chk("sc_dir1", 8'(dir_up), 8'd1);
        chk("sc_tv", 8'(target_valid), 8'd1);
        serve(2'd3);

        // same-floor call and door extension
        cur_floor = 2'd2;
        pulse(3'b010); tick();
        chk("sf_door", 8'(door_cmd), 8'd1);
        chk("sf_tv", 8'(target_valid), 8'd0);
        chk("sf_calls", 8'(calls), 8'h0);
        tick();
        pulse(3'b010);
        chk("sf_ext_calls", 8'(calls), 8'h0);
        chk("sf_ext1", 8'(door_cmd), 8'd1);
        tick(); chk("sf_ext2", 8'(door_cmd), 8'd1);
        tick(); chk("sf_ext3", 8'(door_cmd), 8'd1);
        tick(); chk("sf_ext_end", 8'(door_cmd), 8'd0);

        // emergency halt mid-dispatch
        cur_floor = 2'd1;
        pulse(3'b100); tick();
        chk("em_tv_pre", 8'(target_valid), 8'd1);
        halt = 1'b1; tick();
        chk("em_tv", 8'(target_valid), 8'd0);
        chk("em_door", 8'(door_cmd), 8'd1);
        chk("em_calls", 8'(calls), 8'h4);
        pulse(3'b010);
        chk("em_latch", 8'(calls), 8'h6);
        chk("em_door2", 8'(door_cmd), 8'd1);
        halt = 1'b0; tick();
        chk("em_rel_door", 8'(door_cmd), 8'd0);
        chk("em_rel_tv", 8'(target_valid), 8'd0);
        tick();
        chk("em_re_tv", 8'(target_valid), 8'd1);
        chk("em_re_tgt", 8'(target_floor), 8'd2);

        // reset mid-dispatch with simultaneous calls
        button_reset = 1'b1; call_pulse = 3'b111; tick();
        chk("rr_calls", 8'(calls), 8'h0);
        chk("rr_tv", 8'(target_valid), 8'd0);
        chk("rr_tgt", 8'(target_floor), 8'd1);
        chk("rr_dir", 8'(dir_up), 8'd1);
        chk("rr_door", 8'(door_cmd), 8'd0);
        button_reset = 1'b0; call_pulse = 3'b000;

        // invalid position holds dispatch off
        cur_floor = 2'd0;
        pulse(3'b100); tick(); tick();
        chk("cf0_tv", 8'(target_valid), 8'd0);
        chk("cf0_calls", 8'(calls), 8'h4);
        cur_floor = 2'd1; tick();
        chk("cf1_tv", 8'(target_valid), 8'd1);
        chk("cf1_tgt", 8'(target_floor), 8'd3);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
